// File: rtl/tile_binner.sv
// tile_binner: bins one screen-space triangle into the 32x32 screen tiles its
// clamped pixel bounding box covers, emitting one transaction per tile in
// row-major order. Fully off-screen triangles are dropped.
module tile_binner #(
    parameter int FX_FRAC_BITS = 4,
    parameter int TILE_SHIFT   = 5,
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int TILE_COLS    = SCREEN_W >> TILE_SHIFT,
    parameter int TILE_ROWS    = SCREEN_H >> TILE_SHIFT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tri_vld,
    output logic        tri_rdy,
    input  logic [47:0] tri_v0,
    input  logic [47:0] tri_v1,
    input  logic [47:0] tri_v2,
    input  logic [3:0]  tri_color,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [47:0] out_v0,
    output logic [47:0] out_v1,
    output logic [47:0] out_v2,
    output logic [15:0] out_meta,
    output logic [15:0] tiles_emitted
);

    localparam int TXW = $clog2(TILE_COLS);
    localparam int TYW = $clog2(TILE_ROWS);
    localparam logic signed [11:0] XLIM = 12'(SCREEN_W - 1);
    localparam logic signed [11:0] YLIM = 12'(SCREEN_H - 1);

    typedef enum logic [1:0] {IDLE, SETUP, EMIT} state_t;

    state_t          state_q;
    logic [47:0]     v0_q, v1_q, v2_q;
    logic [3:0]      color_q;
    logic [TXW-1:0]  cur_tx_q, tx_min_q, tx_max_q;
    logic [TYW-1:0]  cur_ty_q, ty_max_q;
    logic [15:0]     cnt_q;

    // Setup datapath: operates on the latched vertices during SETUP.
    logic signed [11:0] x0, x1, x2, y0, y1, y2;
    logic signed [11:0] xmin, xmax, ymin, ymax;
    logic signed [11:0] xlo, xhi, ylo, yhi;
    logic               cull;
    logic [TXW-1:0]     tx_lo, tx_hi;
    logic [TYW-1:0]     ty_lo, ty_hi;

    function automatic logic signed [11:0] min3(input logic signed [11:0] a, b, c);
        logic signed [11:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [11:0] max3(input logic signed [11:0] a, b, c);
        logic signed [11:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Floor to pixels, bound, cull test, clamp and tile-index conversion.
    always_comb begin
        x0 = 12'($signed(v0_q[47:32]) >>> FX_FRAC_BITS);
        x1 = 12'($signed(v1_q[47:32]) >>> FX_FRAC_BITS);
        x2 = 12'($signed(v2_q[47:32]) >>> FX_FRAC_BITS);
        y0 = 12'($signed(v0_q[31:16]) >>> FX_FRAC_BITS);
        y1 = 12'($signed(v1_q[31:16]) >>> FX_FRAC_BITS);
        y2 = 12'($signed(v2_q[31:16]) >>> FX_FRAC_BITS);
        xmin = min3(x0, x1, x2);
        xmax = max3(x0, x1, x2);
        ymin = min3(y0, y1, y2);
        ymax = max3(y0, y1, y2);
        cull = (xmax < 0) || (ymax < 0) || (xmin > XLIM) || (ymin > YLIM);
        xlo  = (xmin < 0) ? 12'sd0 : xmin;
        ylo  = (ymin < 0) ? 12'sd0 : ymin;
        xhi  = (xmax > XLIM) ? XLIM : xmax;
        yhi  = (ymax > YLIM) ? YLIM : ymax;
        // Clamped values are non-negative, so a logical shift is exact.
        tx_lo = TXW'(12'(xlo) >> TILE_SHIFT);
        tx_hi = TXW'(12'(xhi) >> TILE_SHIFT);
        ty_lo = TYW'(12'(ylo) >> TILE_SHIFT);
        ty_hi = TYW'(12'(yhi) >> TILE_SHIFT);
    end

    // Control FSM: accept, one-cycle setup, then walk tiles row-major.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            v0_q     <= '0;
            v1_q     <= '0;
            v2_q     <= '0;
            color_q  <= '0;
            cur_tx_q <= '0;
            cur_ty_q <= '0;
            tx_min_q <= '0;
            tx_max_q <= '0;
            ty_max_q <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tri_vld) begin
                        v0_q    <= tri_v0;
                        v1_q    <= tri_v1;
                        v2_q    <= tri_v2;
                        color_q <= tri_color;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (cull) begin
                        state_q <= IDLE;
                    end else begin
                        cur_tx_q <= tx_lo;
                        cur_ty_q <= ty_lo;
                        tx_min_q <= tx_lo;
                        tx_max_q <= tx_hi;
                        ty_max_q <= ty_hi;
                        state_q  <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_rdy) begin
                        cnt_q <= cnt_q + 16'd1;
                        if (cur_tx_q < tx_max_q) begin
                            cur_tx_q <= cur_tx_q + 1'b1;
                        end else if (cur_ty_q < ty_max_q) begin
                            cur_tx_q <= tx_min_q;
                            cur_ty_q <= cur_ty_q + 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tri_rdy       = (state_q == IDLE) && rst_n;
    assign out_vld       = (state_q == EMIT);
    assign out_v0        = v0_q;
    assign out_v1        = v1_q;
    assign out_v2        = v2_q;
    assign out_meta      = {color_q, 3'b000, cur_ty_q, cur_tx_q};
    assign tiles_emitted = cnt_q;

endmodule

// File: tb/tb_tile_binner.sv
// Bench for tile_binner: directed scenarios plus randomized triangles, all
// checked against a bounding-box tile list computed in plain integer math.
module tb_tile_binner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tri_vld;
    logic        tri_rdy;
    logic [47:0] tri_v0, tri_v1, tri_v2;
    logic [3:0]  tri_color;
    logic        out_vld;
    logic        out_rdy;
    logic [47:0] out_v0, out_v1, out_v2;
    logic [15:0] out_meta;
    logic [15:0] tiles_emitted;

    int n_cmp = 0;
    int n_err = 0;
    int model_cnt = 0;
    logic [15:0] first_meta;
    int n_tiles_seen;

    always #5 clk = ~clk;

    tile_binner dut (
        .clk(clk), .rst_n(rst_n),
        .tri_vld(tri_vld), .tri_rdy(tri_rdy),
        .tri_v0(tri_v0), .tri_v1(tri_v1), .tri_v2(tri_v2), .tri_color(tri_color),
        .out_vld(out_vld), .out_rdy(out_rdy),
        .out_v0(out_v0), .out_v1(out_v1), .out_v2(out_v2),
        .out_meta(out_meta), .tiles_emitted(tiles_emitted)
    );

    // Reference: list of expected out_meta words for a triangle (raw 12.4 coords).
    task automatic model(input int ax, ay, bx, by, cx, cy, input logic [3:0] col,
                         output logic [15:0] q[$]);
        int px[3], py[3];
        int x_lo, x_hi, y_lo, y_hi;
        q = {};
        px[0] = ax >>> 4; px[1] = bx >>> 4; px[2] = cx >>> 4;
        py[0] = ay >>> 4; py[1] = by >>> 4; py[2] = cy >>> 4;
        x_lo = px[0]; x_hi = px[0]; y_lo = py[0]; y_hi = py[0];
        for (int i = 1; i < 3; i++) begin
            if (px[i] < x_lo) x_lo = px[i];
            if (px[i] > x_hi) x_hi = px[i];
            if (py[i] < y_lo) y_lo = py[i];
            if (py[i] > y_hi) y_hi = py[i];
        end
        if (x_hi < 0 || y_hi < 0 || x_lo > 639 || y_lo > 479) return;
        if (x_lo < 0) x_lo = 0;
        if (y_lo < 0) y_lo = 0;
        if (x_hi > 639) x_hi = 639;
        if (y_hi > 479) y_hi = 479;
        for (int ty = y_lo / 32; ty <= y_hi / 32; ty++)
            for (int tx = x_lo / 32; tx <= x_hi / 32; tx++)
                q.push_back(16'((int'(col) << 12) | (ty << 5) | tx));
    endtask

    // Drive one triangle and track its whole transaction stream.
    // rdy_mode 0: out_rdy always 1; 1: random. stall_idx: hold out_rdy low
    // 5 cycles at that tile. rst_idx: pull reset when that tile is presented.
    task automatic run_tri(input int ax, ay, bx, by, cx, cy, input logic [3:0] col,
                           input int rdy_mode, input int stall_idx, input int rst_idx);
        logic [15:0] q[$];
        logic [47:0] e0, e1, e2;
        int idx, stall, waitc, cyc;
        bit culled;
        model(ax, ay, bx, by, cx, cy, col, q);
        culled = (q.size() == 0);
        e0 = {16'(ax), 16'(ay), 16'($urandom)};
        e1 = {16'(bx), 16'(by), 16'($urandom)};
        e2 = {16'(cx), 16'(cy), 16'($urandom)};
        tri_v0 = e0; tri_v1 = e1; tri_v2 = e2; tri_color = col;
        tri_vld = 1'b1;
        waitc = 0;
        while (tri_rdy !== 1'b1 && waitc < 10) begin
            @(negedge clk); waitc++;
        end
        n_cmp++;
        if (tri_rdy !== 1'b1) begin
            n_err++; $display("FAIL accept_wait tri_rdy=%b want 1", tri_rdy);
            tri_vld = 1'b0; return;
        end
        @(negedge clk);
        tri_vld = 1'b0; tri_v0 = '0; tri_v1 = '0; tri_v2 = '0; tri_color = '0;
        n_cmp++;
        if (out_vld !== 1'b0 || tri_rdy !== 1'b0) begin
            n_err++; $display("FAIL setup_cycle out_vld=%b tri_rdy=%b want 0/0", out_vld, tri_rdy);
        end
        @(negedge clk);
        if (culled) begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (out_vld !== 1'b0 || tri_rdy !== 1'b1) begin
                    n_err++; $display("FAIL cull k=%0d out_vld=%b tri_rdy=%b want 0/1", k, out_vld, tri_rdy);
                end
                @(negedge clk);
            end
            n_cmp++;
            if (tiles_emitted !== 16'(model_cnt)) begin
                n_err++; $display("FAIL cull_count got %0d want %0d", tiles_emitted, model_cnt);
            end
            return;
        end
        first_meta = out_meta;
        idx = 0; stall = 0; cyc = 0;
        while (q.size() != 0 && cyc < 4000) begin
            n_cmp++;
            if (out_vld !== 1'b1) begin
                n_err++; $display("FAIL out_vld idx=%0d got %b want 1", idx, out_vld);
            end
            n_cmp++;
            if (out_meta !== q[0]) begin
                n_err++; $display("FAIL meta idx=%0d got %h want %h", idx, out_meta, q[0]);
            end
            n_cmp++;
            if (out_v0 !== e0 || out_v1 !== e1 || out_v2 !== e2) begin
                n_err++; $display("FAIL vert idx=%0d got %h %h %h want %h %h %h",
                                  idx, out_v0, out_v1, out_v2, e0, e1, e2);
            end
            if (idx == rst_idx) begin
                rst_n = 1'b0;
                @(negedge clk);
                n_cmp++;
                if (out_vld !== 1'b0 || tiles_emitted !== 16'd0 || tri_rdy !== 1'b0) begin
                    n_err++; $display("FAIL mid_reset out_vld=%b cnt=%0d tri_rdy=%b want 0/0/0",
                                      out_vld, tiles_emitted, tri_rdy);
                end
                model_cnt = 0;
                rst_n = 1'b1;
                @(negedge clk);
                n_cmp++;
                if (tri_rdy !== 1'b1 || out_vld !== 1'b0) begin
                    n_err++; $display("FAIL post_reset tri_rdy=%b out_vld=%b want 1/0", tri_rdy, out_vld);
                end
                return;
            end
            if (idx == stall_idx && stall < 5) begin
                out_rdy = 1'b0; stall++;
            end else if (rdy_mode == 1) begin
                out_rdy = 1'($urandom_range(0, 1));
            end else begin
                out_rdy = 1'b1;
            end
            if (out_rdy) begin
                void'(q.pop_front());
                idx++; model_cnt++;
            end
            @(negedge clk);
            cyc++;
        end
        out_rdy = 1'b1;
        n_tiles_seen = idx;
        n_cmp++;
        if (q.size() != 0) begin
            n_err++; $display("FAIL timeout left=%0d tiles", q.size());
        end
        n_cmp++;
        if (out_vld !== 1'b0 || tri_rdy !== 1'b1) begin
            n_err++; $display("FAIL end out_vld=%b tri_rdy=%b want 0/1", out_vld, tri_rdy);
        end
        n_cmp++;
        if (tiles_emitted !== 16'(model_cnt)) begin
            n_err++; $display("FAIL count got %0d want %0d", tiles_emitted, model_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tri_vld = 1'b0; out_rdy = 1'b1;
        tri_v0 = '0; tri_v1 = '0; tri_v2 = '0; tri_color = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (out_vld !== 1'b0 || tri_rdy !== 1'b0 || tiles_emitted !== 16'd0 || out_meta !== 16'd0) begin
            n_err++; $display("FAIL reset_hold out_vld=%b tri_rdy=%b cnt=%0d meta=%h want 0/0/0/0",
                              out_vld, tri_rdy, tiles_emitted, out_meta);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (tri_rdy !== 1'b1 || out_vld !== 1'b0 || tiles_emitted !== 16'd0) begin
            n_err++; $display("FAIL reset_release tri_rdy=%b out_vld=%b cnt=%0d want 1/0/0",
                              tri_rdy, out_vld, tiles_emitted);
        end
        model_cnt = 0;
    endtask

    task automatic test_six_tile();
        run_tri(640, 640, 1600, 640, 640, 1440, 4'hA, 0, -1, -1);
        n_cmp++;
        if (first_meta !== 16'hA021 || n_tiles_seen != 6) begin
            n_err++; $display("FAIL six_tile first_meta=%h tiles=%0d want a021/6", first_meta, n_tiles_seen);
        end
    endtask

    task automatic test_single_tile();
        run_tri(80, 80, 160, 80, 80, 160, 4'h3, 0, -1, -1);
        n_cmp++;
        if (first_meta !== 16'h3000 || n_tiles_seen != 1) begin
            n_err++; $display("FAIL single first_meta=%h tiles=%0d want 3000/1", first_meta, n_tiles_seen);
        end
    endtask

    task automatic test_cull();
        run_tri(-800, 0, -160, 800, -480, 1600, 4'h5, 0, -1, -1);
    endtask

    task automatic test_clamp();
        run_tri(-800, 0, 11200, 0, 0, 160, 4'h7, 0, -1, -1);
        n_cmp++;
        if (n_tiles_seen != 20 || first_meta !== 16'h7000) begin
            n_err++; $display("FAIL clamp tiles=%0d first=%h want 20/7000", n_tiles_seen, first_meta);
        end
    endtask

    task automatic test_backpressure();
        run_tri(640, 640, 1600, 640, 640, 1440, 4'hA, 0, 2, -1);
    endtask

    task automatic test_reset_mid_emit();
        run_tri(640, 640, 1600, 640, 640, 1440, 4'hA, 0, -1, 3);
    endtask

    task automatic test_back_to_back();
        run_tri(80, 80, 560, 80, 80, 560, 4'h1, 0, -1, -1);
        run_tri(3200, 3200, 4000, 3300, 3500, 4200, 4'h2, 0, -1, -1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 16; t++) begin
            run_tri(int'($urandom_range(0, 13440)) - 1600, int'($urandom_range(0, 10880)) - 1600,
                    int'($urandom_range(0, 13440)) - 1600, int'($urandom_range(0, 10880)) - 1600,
                    int'($urandom_range(0, 13440)) - 1600, int'($urandom_range(0, 10880)) - 1600,
                    4'($urandom), 1, -1, -1);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_six_tile();
        test_single_tile();
        test_cull();
        test_clamp();
        test_backpressure();
        test_reset_mid_emit();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tile_binner.md
Name: tile_binner

Overview:
- Upstream stage of the raster block. Accepts one screen-space triangle with a colour per handshake.
- Computes the triangle's pixel bounding box, clamps it to the 640x480 screen, and culls fully off-screen triangles.
- Emits one (v0, v1, v2, metadata) transaction per covered tile, row-major, on a valid/ready interface that drives raster's vld_in/ready_in inputs.
- Vertex coordinates are signed 12.4 fixed point (16 bits).

Parameters:
- FX_FRAC_BITS, 4, fractional bits of vertex coordinates.
- TILE_SHIFT, 5, log2 of tile width in pixels (32-pixel tiles).
- SCREEN_W, 640, screen width in pixels.
- SCREEN_H, 480, screen height in pixels.
- TILE_COLS, 20, SCREEN_W >> TILE_SHIFT.
- TILE_ROWS, 15, SCREEN_H >> TILE_SHIFT.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- tri_vld  in  1  input triangle valid
- tri_rdy  out  1  binner can accept a triangle
- tri_v0, tri_v1, tri_v2  in  48 each  {x,y,z} packed, 16-bit signed 12.4 each, x in MSBs
- tri_color  in  4  polygon colour
- out_vld  out  1  tile transaction valid
- out_rdy  in  1  raster ready
- out_v0, out_v1, out_v2  out  48 each  registered copies of accepted vertices
- out_meta  out  16  {color[15:12], 3'b000, tile_y[8:5], tile_x[4:0]}
- tiles_emitted  out  16  count of completed out handshakes since reset, wraps at 2^16

Behaviour:
- Reset is synchronous, active-low; reset rst_n, clock clk.
- While rst_n is low:
  - state=IDLE, out_vld=0, tri_rdy=0, tiles_emitted=0.
  - out_v*/out_meta reset to 0.
- tri_rdy = (state==IDLE) && rst_n. It is high in the first cycle after reset release.
- States: IDLE, SETUP, EMIT.
- IDLE:
  - On tri_vld && tri_rdy, latch vertices and colour, then go to SETUP.
  - tri_vld without tri_rdy is ignored.
- SETUP (exactly 1 cycle):
  - Pixel coordinate = arithmetic shift right of x/y by FX_FRAC_BITS (floor).
  - xmin/xmax/ymin/ymax are min/max over the 3 vertices.
  - Cull if xmax<0, ymax<0, xmin>SCREEN_W-1, or ymin>SCREEN_H-1. On cull go to IDLE; no output is produced.
  - Otherwise clamp mins to >=0 and maxes to <=SCREEN_W-1 / SCREEN_H-1.
  - Tile bounds = clamped >> TILE_SHIFT.
  - Set cur_tx=tx_min, cur_ty=ty_min, then go to EMIT.
- EMIT:
  - out_vld=1. out_meta tile fields = cur_tx/cur_ty; colour = latched colour.
  - On out_vld && out_rdy, increment tiles_emitted and advance:
    - If cur_tx<tx_max: cur_tx++.
    - Else if cur_ty<ty_max: cur_tx=tx_min, cur_ty++.
    - Else go to IDLE, with out_vld=0 in the next cycle.
- out_v*/out_meta colour are stable from SETUP exit until return to IDLE.
- While out_vld=1 && out_rdy=0, every out_* field holds.
- Latency: accept at edge N gives the first out_vld at edge N+2. Culled triangle: tri_rdy high again at edge N+2.
- Throughput: one tile per cycle under continuous out_rdy. A new triangle is accepted no earlier than the cycle after the last tile handshake.
- Degenerate (zero-area) triangles are not culled; the bounding box alone governs emission.
- Reset mid-EMIT: the transaction is abandoned; out_vld=0 while rst_n is low.
- Internal widths: pixel values are 12-bit signed; comparisons are signed.

Test Plan:
- Reset hold 3 cycles, release -> out_vld=0, tiles_emitted=0, tri_rdy=1 on the first cycle after release.
- Triangle (40,40),(100,40),(40,90), raw x/y 640,1600,640 / 640,640,1440, colour 0xA, out_rdy=1 -> 6 tiles, meta order (tx,ty) (1,1),(2,1),(3,1),(1,2),(2,2),(3,2). First out_meta=0xA021. tiles_emitted=6. tri_rdy returns after the last handshake.
- Triangle (5,5),(10,5),(5,10) -> exactly one tile (0,0). Accepted at edge N, out_vld at N+2.
- All x in [-50,-10] -> culled. No out_vld. tri_rdy=1 two cycles after accept. tiles_emitted unchanged.
- x span -50..700, y 0..10 -> clamped to tiles tx 0..19, ty 0 -> 20 transactions.
- Backpressure: in the 6-tile case, drop out_rdy for 5 cycles at the 3rd tile -> out_meta holds (3,1), no skip or duplicate. Separately, assert rst_n=0 during the 4th tile -> out_vld=0 next cycle, tiles_emitted=0.
